inst_loader: RTL and testbench

- Byte-serial program loader; the write side of instruction memory, whose read side is the CPU fetch path (readAddress = PC, word-aligned byte address).
- Receives a framed byte stream: length byte, 4·N instruction bytes, checksum byte.
- Assembles big-endian 32-bit words and issues one write per word to instruction memory at byte addresses 0, 4, 8, …
- Holds the CPU in reset (cpuHold) while a load is in progress or has failed.

---
 rtl/inst_loader.sv | 186 ++++++++++++++++++
 tb/tb_inst_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//
// Byte-serial program loader that forms the write side of the instruction
// memory. It receives a framed byte stream (length byte, 4*N instruction
// bytes, checksum byte), assembles big-endian 32-bit words and issues one
// write strobe per word at byte addresses 0, 4, 8, ... While a load is in
// progress, or after a failed load, the CPU is held in reset via cpuHold.
//
// Ports:
//   clock_in      : system clock, all state changes on the rising edge
//   reset         : synchronous, active-high reset
//   start         : one-cycle pulse, begins a load from IDLE, DONE or ERROR
//   byteIn        : stream byte
//   byteValid     : byteIn is valid this cycle
//   byteReady     : loader accepts a byte this cycle (transfer = valid&&ready)
//   memAddress    : instruction memory byte address (word aligned)
//   memWriteData  : instruction word to write
//   memWrite      : one-cycle write strobe
//   cpuHold       : CPU reset request, high while loading or in ERROR
//   done          : load finished with a good checksum
//   error         : load failed (bad length or bad checksum)
//
// Parameter:
//   MEM_WORDS     : instruction memory depth in words, 1..255
// ---------------------------------------------------------------------------
module inst_loader #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWrite,
  output logic        cpuHold,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] MaxLength = 8'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    COLLECT,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t      state_q;
  logic [7:0]  wordIndex_q;
  logic [1:0]  byteIndex_q;
  logic [7:0]  sum_q;
  logic [7:0]  length_q;
  logic [31:0] wordBuf_q;
  logic [31:0] memAddress_q;
  logic [31:0] memWriteData_q;
  logic        memWrite_q;
  logic        cpuHold_q;
  logic        done_q;
  logic        error_q;
  logic        byteReady_q;

  // Next-value helpers shared by several FSM branches.
  logic        transfer_d;
  logic [7:0]  sumNext_d;
  logic [7:0]  wordIndexNext_d;
  logic [31:0] wordBufNext_d;

  assign transfer_d      = byteValid && byteReady_q;
  assign sumNext_d       = sum_q + byteIn;
  assign wordIndexNext_d = wordIndex_q + 8'd1;
  // First byte of a word ends up in [31:24] after four shifts (big-endian).
  assign wordBufNext_d   = {wordBuf_q[23:0], byteIn};

  // Single FSM with registered outputs. byteReady_q is kept equal to
  // "state is LEN, COLLECT or CHECK" by updating it on every transition.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q        <= IDLE;
      wordIndex_q    <= 8'd0;
      byteIndex_q    <= 2'd0;
      sum_q          <= 8'd0;
      length_q       <= 8'd0;
      wordBuf_q      <= 32'd0;
      memAddress_q   <= 32'd0;
      memWriteData_q <= 32'd0;
      memWrite_q     <= 1'b0;
      cpuHold_q      <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      byteReady_q    <= 1'b0;
    end else begin
      memWrite_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_q     <= LEN;
            wordIndex_q <= 8'd0;
            byteIndex_q <= 2'd0;
            sum_q       <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpuHold_q   <= 1'b1;
            byteReady_q <= 1'b1;
          end
        end

        LEN: begin
          if (transfer_d) begin
            length_q <= byteIn;
            if (byteIn == 8'd0 || byteIn > MaxLength) begin
              state_q     <= ERROR;
              error_q     <= 1'b1;
              byteReady_q <= 1'b0;
            end else begin
              state_q <= COLLECT;
            end
          end
        end

        COLLECT: begin
          if (transfer_d) begin
            wordBuf_q   <= wordBufNext_d;
            sum_q       <= sumNext_d;
            byteIndex_q <= byteIndex_q + 2'd1;
            // Fourth byte: the strobe is registered here so it is high
            // during the single WRITE cycle that follows.
            if (byteIndex_q == 2'd3) begin
              state_q        <= WRITE;
              memWrite_q     <= 1'b1;
              memAddress_q   <= {22'd0, wordIndex_q, 2'b00};
              memWriteData_q <= wordBufNext_d;
              byteReady_q    <= 1'b0;
            end
          end
        end

        WRITE: begin
          wordIndex_q <= wordIndexNext_d;
          byteReady_q <= 1'b1;
          if (wordIndexNext_d == length_q) begin
            state_q <= CHECK;
          end else begin
            state_q <= COLLECT;
          end
        end

        CHECK: begin
          if (transfer_d) begin
            byteReady_q <= 1'b0;
            if (byteIn == sum_q) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              cpuHold_q <= 1'b0;
            end else begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          cpuHold_q   <= 1'b0;
          byteReady_q <= 1'b0;
        end
      endcase
    end
  end

  assign byteReady    = byteReady_q;
  assign memAddress   = memAddress_q;
  assign memWriteData = memWriteData_q;
  assign memWrite     = memWrite_q;
  assign cpuHold      = cpuHold_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_loader
//
// Self-checking bench for inst_loader. A frame-level reference model tracks
// how many bytes of the current frame have been consumed and derives every
// output from that count; a compare process checks all DUT outputs against
// it on every falling edge. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_inst_loader;

  logic        clock_in = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'd0;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic        cpuHold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  logic [7:0]  frame[$];
  logic [31:0] capAddr[$];
  logic [31:0] capData[$];

  inst_loader #(.MEM_WORDS(64)) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .start       (start),
    .byteIn      (byteIn),
    .byteValid   (byteValid),
    .byteReady   (byteReady),
    .memAddress  (memAddress),
    .memWriteData(memWriteData),
    .memWrite    (memWrite),
    .cpuHold     (cpuHold),
    .done        (done),
    .error       (error)
  );

  always #5 clock_in = ~clock_in;

  // Frame-level model: cnt counts consumed frame bytes (0 = length byte next),
  // wrPending marks the cycle in which a completed word is being written.
  typedef struct {
    bit          loading;
    int          cnt;
    int          lenVal;
    logic [7:0]  sum;
    logic [31:0] word;
    bit          wrPending;
    logic [31:0] lastAddr;
    logic [31:0] lastData;
    int          result;
  } model_t;

  model_t m;

  function automatic model_t modelReset();
    model_t z;
    z.loading   = 1'b0;
    z.cnt       = 0;
    z.lenVal    = 0;
    z.sum       = 8'd0;
    z.word      = 32'd0;
    z.wrPending = 1'b0;
    z.lastAddr  = 32'd0;
    z.lastData  = 32'd0;
    z.result    = 0;
    return z;
  endfunction

  function automatic model_t modelStep(model_t c, logic rst, logic st, logic bv, logic [7:0] b);
    model_t n;
    n = c;
    if (rst) return modelReset();
    n.wrPending = 1'b0;
    if (!c.wrPending) begin
      if (!c.loading) begin
        if (st) begin
          n.loading = 1'b1;
          n.cnt     = 0;
          n.sum     = 8'd0;
          n.result  = 0;
        end
      end else if (bv) begin
        if (c.cnt == 0) begin
          n.lenVal = int'(b);
          n.cnt    = 1;
          if (b == 8'd0 || int'(b) > 64) begin
            n.loading = 1'b0;
            n.result  = 2;
          end
        end else if (c.cnt <= 4 * c.lenVal) begin
          n.word = {c.word[23:0], b};
          n.sum  = c.sum + b;
          if (c.cnt % 4 == 0) begin
            n.wrPending = 1'b1;
            n.lastAddr  = 32'((c.cnt / 4 - 1) * 4);
            n.lastData  = n.word;
          end
          n.cnt = c.cnt + 1;
        end else begin
          n.loading = 1'b0;
          n.result  = (b == c.sum) ? 1 : 2;
        end
      end
    end
    return n;
  endfunction

  // Model advances on the same edge as the DUT, from the same inputs.
  always @(posedge clock_in) m <= modelStep(m, reset, start, byteValid, byteIn);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checkOutput(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock_in) begin
    if (checking) begin
      checkFlag("byteReady", byteReady, m.loading && !m.wrPending);
      checkFlag("memWrite", memWrite, m.wrPending);
      checkOutput("memAddress", memAddress, m.lastAddr);
      checkOutput("memWriteData", memWriteData, m.lastData);
      checkFlag("cpuHold", cpuHold, m.loading || m.result == 2);
      checkFlag("done", done, m.result == 1);
      checkFlag("error", error, m.result == 2);
    end
  end

  // Record every write strobe for the directed literal checks.
  always @(negedge clock_in) begin
    if (checking && memWrite === 1'b1) begin
      capAddr.push_back(memAddress);
      capData.push_back(memWriteData);
    end
  end

  // Drive one cycle of inputs (called just after a falling edge).
  task automatic applyStimulus(input logic st, input logic bv, input logic [7:0] b);
    start     = st;
    byteValid = bv;
    byteIn    = b;
    @(negedge clock_in);
  endtask

  // Present a byte and hold it until the handshake completes.
  task automatic sendByte(input logic [7:0] b, input bit noise);
    int tries;
    bit acc;
    tries = 0;
    acc   = 1'b0;
    if (noise) begin
      repeat ($urandom_range(0, 2)) applyStimulus($urandom_range(0, 3) == 0, 1'b0, 8'($urandom));
    end
    while (!acc && tries < 40) begin
      acc = byteReady;
      applyStimulus(noise && ($urandom_range(0, 5) == 0), 1'b1, b);
      tries++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL byteAccept actual=not_accepted required=accepted byte=%0h", b);
    end
  endtask

  task automatic sendFrame(input bit noise);
    foreach (frame[i]) sendByte(frame[i], noise && i > 0);
    applyStimulus(1'b0, 1'b0, 8'd0);
  endtask

  task automatic beginLoad();
    capAddr.delete();
    capData.delete();
    applyStimulus(1'b1, 1'b0, 8'd0);
  endtask

  task automatic buildFrame(input int len, input bit badSum);
    logic [7:0] s;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'(len));
    if (len >= 1 && len <= 64) begin
      s = 8'd0;
      for (int i = 0; i < 4 * len; i++) begin
        b = 8'($urandom);
        frame.push_back(b);
        s = s + b;
      end
      frame.push_back(badSum ? (s ^ 8'h01) : s);
    end
  endtask

  task automatic loadGoodExample(input logic [7:0] chk);
    frame = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, chk};
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    repeat (2) @(negedge clock_in);
    checking = 1'b1;
    @(negedge clock_in);
    checkFlag("resetCpuHold", cpuHold, 1'b0);
    checkFlag("resetReady", byteReady, 1'b0);
    checkOutput("resetAddr", memAddress, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0);

    // Good load
    beginLoad();
    loadGoodExample(8'h2D);
    sendFrame(1'b0);
    checkOutput("goodWriteCount", 32'(capAddr.size()), 32'd2);
    if (capAddr.size() >= 2) begin
      checkOutput("goodAddr0", capAddr[0], 32'h0);
      checkOutput("goodData0", capData[0], 32'h20080005);
      checkOutput("goodAddr1", capAddr[1], 32'h4);
      checkOutput("goodData1", capData[1], 32'h00000000);
    end
    checkFlag("goodDone", done, 1'b1);
    checkFlag("goodError", error, 1'b0);
    checkFlag("goodHold", cpuHold, 1'b0);
    checkOutput("modelGoodResult", 32'(m.result), 32'd1);

    // Bad lengths: zero and one beyond the memory depth
    beginLoad();
    frame = '{8'h00};
    sendFrame(1'b0);
    checkFlag("len0Error", error, 1'b1);
    checkFlag("len0Hold", cpuHold, 1'b1);
    checkOutput("len0Writes", 32'(capAddr.size()), 32'd0);
    beginLoad();
    frame = '{8'h41};
    sendFrame(1'b0);
    checkFlag("len41Error", error, 1'b1);
    checkFlag("len41Hold", cpuHold, 1'b1);
    checkOutput("len41Writes", 32'(capAddr.size()), 32'd0);

    // Bad checksum, then recovery with a good stream
    beginLoad();
    loadGoodExample(8'h2C);
    sendFrame(1'b0);
    checkOutput("badSumWrites", 32'(capAddr.size()), 32'd2);
    checkFlag("badSumError", error, 1'b1);
    checkFlag("badSumDone", done, 1'b0);
    checkFlag("badSumHold", cpuHold, 1'b1);
    beginLoad();
    loadGoodExample(8'h2D);
    sendFrame(1'b0);
    checkFlag("recoverDone", done, 1'b1);
    checkFlag("recoverError", error, 1'b0);

    // Byte AA held valid through the WRITE cycle of word 0
    beginLoad();
    frame = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8};
    sendFrame(1'b0);
    if (capData.size() >= 2) begin
      checkOutput("stallData0", capData[0], 32'h11223344);
      checkOutput("stallData1", capData[1], 32'hAABBCCDD);
    end else begin
      checkOutput("stallWriteCount", 32'(capData.size()), 32'd2);
    end
    checkFlag("stallDone", done, 1'b1);

    // Reset mid-load, with start asserted in the reset cycle
    beginLoad();
    frame = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    foreach (frame[i]) sendByte(frame[i], 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h55);
    reset = 1'b0;
    checkFlag("rstReady", byteReady, 1'b0);
    checkFlag("rstWrite", memWrite, 1'b0);
    checkOutput("rstAddr", memAddress, 32'd0);
    checkOutput("rstData", memWriteData, 32'd0);
    checkFlag("rstHold", cpuHold, 1'b0);
    checkFlag("rstDone", done, 1'b0);
    checkFlag("rstError", error, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkFlag("rstStartIgnored", cpuHold, 1'b0);

    // Bytes in IDLE are ignored; start pulses during COLLECT are ignored
    capAddr.delete();
    capData.delete();
    repeat (3) applyStimulus(1'b0, 1'b1, 8'($urandom));
    checkOutput("idleBytesWrites", 32'(capAddr.size()), 32'd0);
    beginLoad();
    buildFrame(3, 1'b0);
    sendFrame(1'b1);
    checkFlag("noisyDone", done, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1, 8'($urandom));
    checkFlag("doneBytesDone", done, 1'b1);
    checkOutput("doneBytesWrites", 32'(capAddr.size()), 32'd3);
    beginLoad();
    buildFrame(2, 1'b0);
    sendFrame(1'b0);
    if (capAddr.size() >= 1) checkOutput("restartAddr0", capAddr[0], 32'd0);
    checkFlag("restartDone", done, 1'b1);

    // Randomised loads checked cycle by cycle against the model
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'b1, 8'($urandom));
      end
      if ($urandom_range(0, 9) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 255));
      end else if ($urandom_range(0, 9) == 0) begin
        len = 64;
      end else begin
        len = int'($urandom_range(1, 12));
      end
      beginLoad();
      buildFrame(len, $urandom_range(0, 3) == 0);
      sendFrame(1'b1);
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0, 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
